// File: rtl/lc3_mem_responder.sv
// LC3 memory responder: word-addressed storage shared by an instruction-fetch
// port and a data port. Each port runs its own two-state handshake with a
// fixed latency and a one-cycle completion pulse. A separate preload port
// writes memory directly, whatever the ports are doing.
module lc3_mem_responder #(
  parameter int DEPTH     = 256,
  parameter int INSTR_LAT = 1,
  parameter int DATA_LAT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic [15:0] Data_addr,
  input  logic        data_en,
  input  logic        Data_rd,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data
);

  localparam int AW = $clog2(DEPTH);
  // The counter starts at LAT-1, so completion lands exactly LAT edges after acceptance.
  localparam logic [3:0] INSTR_RELOAD = 4'(INSTR_LAT - 1);
  localparam logic [3:0] DATA_RELOAD  = 4'(DATA_LAT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } port_state_e;

  // Storage is deliberately left without a reset so contents survive reset.
  logic [15:0] mem_q [DEPTH];

  // Instruction port state
  port_state_e istate_q, istate_d;
  logic [3:0]    icnt_q, icnt_d;
  logic [AW-1:0] iaddr_q, iaddr_d;
  logic          ifire_s;

  // Data port state
  port_state_e dstate_q, dstate_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic [AW-1:0] daddr_q, daddr_d;
  logic          drd_q, drd_d;
  logic [15:0]   ddin_q, ddin_d;
  logic          dfire_s;

  // Registered outputs
  logic [15:0] instr_dout_q;
  logic        complete_instr_q;
  logic [15:0] data_dout_q;
  logic        complete_data_q;

  // Only the low AW address bits index memory; the upper bits wrap away.
  if (AW < 16) begin : g_unused_hi
    logic unused_hi_s;
    assign unused_hi_s = ^{pc[15:AW], Data_addr[15:AW], load_addr[15:AW]};
  end

  // Instruction port next state: accept in IDLE, count down in WAIT, fire at zero.
  always_comb begin
    istate_d = istate_q;
    icnt_d   = icnt_q;
    iaddr_d  = iaddr_q;
    ifire_s  = 1'b0;
    case (istate_q)
      IDLE: begin
        if (instrmem_rd) begin
          istate_d = WAIT;
          icnt_d   = INSTR_RELOAD;
          iaddr_d  = pc[AW-1:0];
        end else begin
          istate_d = IDLE;
        end
      end
      WAIT: begin
        if (icnt_q == 4'd0) begin
          ifire_s  = 1'b1;
          istate_d = IDLE;
        end else begin
          icnt_d = icnt_q - 4'd1;
        end
      end
      default: begin
        istate_d = IDLE;
        icnt_d   = 4'd0;
      end
    endcase
  end

  // Instruction port state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      istate_q <= IDLE;
      icnt_q   <= 4'd0;
      iaddr_q  <= '0;
    end else begin
      istate_q <= istate_d;
      icnt_q   <= icnt_d;
      iaddr_q  <= iaddr_d;
    end
  end

  // Data port next state: latch address, direction and write data on accept.
  always_comb begin
    dstate_d = dstate_q;
    dcnt_d   = dcnt_q;
    daddr_d  = daddr_q;
    drd_d    = drd_q;
    ddin_d   = ddin_q;
    dfire_s  = 1'b0;
    case (dstate_q)
      IDLE: begin
        if (data_en) begin
          dstate_d = WAIT;
          dcnt_d   = DATA_RELOAD;
          daddr_d  = Data_addr[AW-1:0];
          drd_d    = Data_rd;
          ddin_d   = Data_din;
        end else begin
          dstate_d = IDLE;
        end
      end
      WAIT: begin
        if (dcnt_q == 4'd0) begin
          dfire_s  = 1'b1;
          dstate_d = IDLE;
        end else begin
          dcnt_d = dcnt_q - 4'd1;
        end
      end
      default: begin
        dstate_d = IDLE;
        dcnt_d   = 4'd0;
      end
    endcase
  end

  // Data port state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dstate_q <= IDLE;
      dcnt_q   <= 4'd0;
      daddr_q  <= '0;
      drd_q    <= 1'b0;
      ddin_q   <= 16'h0000;
    end else begin
      dstate_q <= dstate_d;
      dcnt_q   <= dcnt_d;
      daddr_q  <= daddr_d;
      drd_q    <= drd_d;
      ddin_q   <= ddin_d;
    end
  end

  // Memory writes: preload first, then the data-port write so it wins on the same word.
  // A write aborted by reset never fires because the port state is already IDLE.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem_q[load_addr[AW-1:0]] <= load_data;
    end
    if (dfire_s && !drd_q) begin
      mem_q[daddr_q] <= ddin_q;
    end
  end

  // Instruction outputs: read at completion (pre-write value), pulse complete once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      complete_instr_q <= 1'b0;
      instr_dout_q     <= 16'h0000;
    end else begin
      complete_instr_q <= ifire_s;
      if (ifire_s) begin
        instr_dout_q <= mem_q[iaddr_q];
      end
    end
  end

  // Data outputs: only a read completion updates Data_dout; writes leave it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      complete_data_q <= 1'b0;
      data_dout_q     <= 16'h0000;
    end else begin
      complete_data_q <= dfire_s;
      if (dfire_s && drd_q) begin
        data_dout_q <= mem_q[daddr_q];
      end
    end
  end

  assign Instr_dout     = instr_dout_q;
  assign complete_instr = complete_instr_q;
  assign Data_dout      = data_dout_q;
  assign complete_data  = complete_data_q;

endmodule
